field_display_engine: RTL

- Parametrised successor to the 184-bit byte-window hex display block on the DE2 board.
- Extracts a 1..MAX_FIELD_BYTES byte field from a wide captured word, such as the Rabbit DDS frame.
- Renders the field on NUM_DIGITS active-low 7-segment displays, in hex or in decimal (BCD via sequential double-dabble).
- Adds a GO/BUSY/DONE handshake, a sticky error flag, leading-zero blanking control and a decimal overflow flag.

---
 rtl/field_display_engine.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/field_display_engine.sv
// Byte-field extractor and 7-segment renderer for a wide captured word.
// Hex or decimal output; decimal uses a sequential double-dabble converter.
module field_display_engine #(
  parameter int WORD_BYTES      = 23,
  parameter int MAX_FIELD_BYTES = 4,
  parameter int NUM_DIGITS      = 8,
  parameter int SEL_W           = 5
) (
  input  logic                         FITTYMEGA,
  input  logic                         RESET,
  input  logic [0:8*WORD_BYTES-1]      whole_word,
  input  logic [SEL_W-1:0]             START_BYTE,
  input  logic [SEL_W-1:0]             END_BYTE,
  input  logic                         DEC_MODE,
  input  logic                         BLANK_ZEROS,
  input  logic                         GO,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERROR,
  output logic                         OVERFLOW,
  output logic [8*MAX_FIELD_BYTES-1:0] VALUE,
  output logic [7*NUM_DIGITS-1:0]      HexDisplay_output
);

  localparam int VW = 8 * MAX_FIELD_BYTES;
  localparam int BW = 4 * NUM_DIGITS;
  localparam int HW = (VW > BW) ? VW : BW;
  localparam int CW = (VW > 2) ? $clog2(VW) : 1;

  // states: IDLE wait GO | LOAD validate+extract | DABBLE binary->BCD | RENDER drive segments
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DABBLE, S_RENDER} state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       start_q, start_d, end_q, end_d;
  logic                   dec_q, dec_d, blank_q, blank_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   error_q, error_d, ovf_q, ovf_d;
  logic [VW-1:0]          value_q, value_d, shift_q, shift_d;
  logic [BW-1:0]          bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7*NUM_DIGITS-1:0] disp_q, disp_d, disp_render;
  logic [VW-1:0]          field;
  logic [HW-1:0]          hex_wide;
  logic [3:0]             nib;
  logic                   lead;
  logic                   sel_bad;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0011000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign sel_bad = (end_q < start_q) ||
                   (int'(end_q) - int'(start_q) >= MAX_FIELD_BYTES) ||
                   (int'(end_q) >= WORD_BYTES);

  always_comb begin
    field = '0;
    for (int i = 0; i < MAX_FIELD_BYTES; i++) begin
      if ((int'(start_q) + i <= int'(end_q)) && (int'(start_q) + i < WORD_BYTES))
        field[8*i +: 8] = whole_word[8*(int'(start_q) + i) +: 8];
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  // Walk digits from the top; blanking stops at the first non-zero digit or digit 0.
  always_comb begin
    hex_wide    = HW'(value_q);
    lead        = 1'b1;
    nib         = 4'd0;
    disp_render = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = dec_q ? bcd_q[4*i +: 4] : hex_wide[4*i +: 4];
      if (blank_q && lead && (nib == 4'd0) && (i != 0)) begin
        disp_render[7*i +: 7] = 7'h7F;
      end else begin
        disp_render[7*i +: 7] = seg7(nib);
        lead = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    end_d   = end_q;
    dec_d   = dec_q;
    blank_d = blank_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    ovf_d   = ovf_q;
    value_d = value_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    case (state_q)
      S_IDLE: begin
        if (GO) begin
          start_d = START_BYTE;
          end_d   = END_BYTE;
          dec_d   = DEC_MODE;
          blank_d = BLANK_ZEROS;
          error_d = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (sel_bad) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          value_d = field;
          shift_d = field;
          bcd_d   = '0;
          cnt_d   = CW'(VW - 1);
          state_d = dec_q ? S_DABBLE : S_RENDER;
        end
      end
      S_DABBLE: begin
        bcd_d   = {bcd_adj[BW-2:0], shift_q[VW-1]};
        shift_d = {shift_q[VW-2:0], 1'b0};
        if (bcd_adj[BW-1])
          ovf_d = 1'b1;
        if (cnt_q == '0)
          state_d = S_RENDER;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: begin
        disp_d  = disp_render;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge FITTYMEGA or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      start_q <= '0;
      end_q   <= '0;
      dec_q   <= 1'b0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ovf_q   <= 1'b0;
      value_q <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '1;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      dec_q   <= dec_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      ovf_q   <= ovf_d;
      value_q <= value_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  assign BUSY              = busy_q;
  assign DONE              = done_q;
  assign ERROR             = error_q;
  assign OVERFLOW          = ovf_q;
  assign VALUE             = value_q;
  assign HexDisplay_output = disp_q;

endmodule
